// File: rtl/pwm_shift_scheduler_pkg.sv
// Shared parameters, FSM state type and the per-step compare used by the serial PWM scheduler.
// Pure declarations: no latency, no flow control.
package pwm_pkg;

  localparam int CHANNELS = 8;
  localparam int PERIOD   = 100;
  localparam int DUTY_W   = 8;
  localparam int CH_W     = $clog2(CHANNELS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  typedef logic [DUTY_W-1:0] duty_t;

  // Unsigned compare: duty 0 never fires, duty >= PERIOD always fires.
  function automatic logic pwm_bit(input duty_t count, input duty_t duty);
    return count < duty;
  endfunction

endpackage

// File: rtl/pwm_shift_scheduler_if.sv
// Config inputs and ShiftReg-side outputs of the scheduler, bundled for the top-level port.
// master = driver/config side, slave = scheduler side; no flow control, strobes are single-cycle.
interface pwm_shift_scheduler_if;
  import pwm_pkg::*;

  logic            enable;
  logic            cfg_we;
  logic [CH_W-1:0] cfg_addr;
  duty_t           cfg_duty;
  logic            s_data;
  logic            s_shift;
  logic            s_latch;
  logic            period_start;
  logic            busy;

  modport master (
    output enable, cfg_we, cfg_addr, cfg_duty,
    input  s_data, s_shift, s_latch, period_start, busy
  );

  modport slave (
    input  enable, cfg_we, cfg_addr, cfg_duty,
    output s_data, s_shift, s_latch, period_start, busy
  );

endinterface

// File: rtl/pwm_shift_scheduler_duty_bank.sv
// Double-buffered duty storage: writes land in pending, commit copies pending (with write-through) to active.
// Writes take one clock, reads of active are combinational; never stalls.
module pwm_duty_bank
  import pwm_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [CH_W-1:0] wr_addr,
  input  duty_t           wr_duty,
  input  logic            commit,
  input  logic [CH_W-1:0] rd_idx,
  output duty_t           rd_duty
);

  duty_t pending_q [CHANNELS];
  duty_t pending_d [CHANNELS];
  duty_t active_q  [CHANNELS];
  duty_t active_d  [CHANNELS];

  always_comb begin
    pending_d = pending_q;
    // Matching against each legal index leaves any unmapped address without effect.
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_en && (wr_addr == CH_W'(i))) begin
        pending_d[i] = wr_duty;
      end
    end
    active_d = active_q;
    if (commit) begin
      active_d = pending_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pending_q[i] <= '0;
        active_q[i]  <= '0;
      end
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  assign rd_duty = active_q[rd_idx];

endmodule

// File: rtl/pwm_shift_scheduler.sv
// Frame sequencer for the serial PWM path: 8 shift cycles, highest channel first, then one latch cycle.
// Outputs are registered one clock behind the FSM state; no backpressure, enable is sampled at frame end.
module pwm_shift_scheduler
  import pwm_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  pwm_shift_scheduler_if.slave  bus
);

  state_e          state_q, state_d;
  logic [CH_W-1:0] idx_q, idx_d;
  duty_t           pwm_count_q, pwm_count_d;
  logic            s_data_q, s_data_d;
  logic            s_shift_q, s_shift_d;
  logic            s_latch_q, s_latch_d;
  logic            period_start_q, period_start_d;
  logic            busy_q, busy_d;

  logic            at_wrap;
  logic            commit;
  logic [CH_W-1:0] rd_idx;
  duty_t           rd_duty;

  assign at_wrap = (pwm_count_q == DUTY_W'(PERIOD - 1));
  assign rd_idx  = CH_W'(CHANNELS - 1) - idx_q;
  // Duties swap only where a new period begins: the wrapping latch, or a fresh start at count 0.
  assign commit  = ((state_q == LATCH) && at_wrap) ||
                   ((state_q == IDLE) && bus.enable && (pwm_count_q == '0));

  pwm_duty_bank u_duty_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.cfg_we),
    .wr_addr (bus.cfg_addr),
    .wr_duty (bus.cfg_duty),
    .commit  (commit),
    .rd_idx  (rd_idx),
    .rd_duty (rd_duty)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    pwm_count_d    = pwm_count_q;
    s_data_d       = 1'b0;
    s_shift_d      = 1'b0;
    s_latch_d      = 1'b0;
    period_start_d = 1'b0;
    busy_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (bus.enable) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        s_shift_d = 1'b1;
        s_data_d  = pwm_bit(pwm_count_q, rd_duty);
        busy_d    = 1'b1;
        if (idx_q == CH_W'(CHANNELS - 1)) begin
          idx_d   = '0;
          state_d = LATCH;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      LATCH: begin
        s_latch_d      = 1'b1;
        busy_d         = 1'b1;
        period_start_d = (pwm_count_q == '0);
        pwm_count_d    = at_wrap ? '0 : pwm_count_q + 1'b1;
        state_d        = bus.enable ? SHIFT : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      pwm_count_q    <= '0;
      s_data_q       <= 1'b0;
      s_shift_q      <= 1'b0;
      s_latch_q      <= 1'b0;
      period_start_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      pwm_count_q    <= pwm_count_d;
      s_data_q       <= s_data_d;
      s_shift_q      <= s_shift_d;
      s_latch_q      <= s_latch_d;
      period_start_q <= period_start_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.s_data       = s_data_q;
  assign bus.s_shift      = s_shift_q;
  assign bus.s_latch      = s_latch_q;
  assign bus.period_start = period_start_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_pwm_shift_scheduler.sv
// Directed bench for pwm_shift_scheduler: frame timing, double-buffered duty commits, enable drop and async reset.
module tb_pwm_shift_scheduler;
  import pwm_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pwm_shift_scheduler_if bus ();

  pwm_shift_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  int wr_addr_at [PERIOD];
  int wr_val_at  [PERIOD];
  int exp_duty   [CHANNELS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_writes();
    for (int f = 0; f < PERIOD; f++) begin
      wr_addr_at[f] = -1;
      wr_val_at[f]  = 0;
    end
  endtask

  // Collects one frame; an optional write is held during the FSM's latch cycle (last bit visible).
  task automatic capture_frame(input bit do_wr, input int wr_addr, input int wr_val,
                               output logic [7:0] bits, output logic ps);
    int   n;
    logic shift_ok;
    n        = 0;
    shift_ok = 1'b1;
    bits     = '0;
    while (bus.s_shift !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check("frame_start", bus.s_shift, 1);
    for (int k = 0; k < CHANNELS; k++) begin
      bits[CHANNELS-1-k] = bus.s_data;
      if (bus.s_shift !== 1'b1) shift_ok = 1'b0;
      if (k == CHANNELS - 1 && do_wr) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = wr_addr[CH_W-1:0];
        bus.cfg_duty = wr_val[7:0];
      end
      step();
    end
    bus.cfg_we = 1'b0;
    check("shift_run", shift_ok, 1);
    check("latch_cycle", {bus.s_latch, bus.s_shift, bus.s_data, bus.busy}, 4'b1001);
    ps = bus.period_start;
  endtask

  task automatic run_period(input string tag, input int first_f);
    logic [7:0] bits;
    logic [7:0] expb;
    logic       ps;
    for (int f = first_f; f < PERIOD; f++) begin
      capture_frame(wr_addr_at[f] >= 0, wr_addr_at[f], wr_val_at[f], bits, ps);
      for (int c = 0; c < CHANNELS; c++) expb[c] = (f < exp_duty[c]);
      check($sformatf("%s_bits_f%0d", tag, f), bits, expb);
      check($sformatf("%s_pstart_f%0d", tag, f), ps, (f == 0));
    end
  endtask

  initial begin
    logic [7:0] bits;
    logic       ps;
    logic       seen;
    int         n;

    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_duty = '0;
    clear_writes();
    repeat (3) @(negedge clk);

    check("rst_s_data", bus.s_data, 0);
    check("rst_s_shift", bus.s_shift, 0);
    check("rst_s_latch", bus.s_latch, 0);
    check("rst_period_start", bus.period_start, 0);
    check("rst_busy", bus.busy, 0);

    reset = 1'b0;
    step();
    check("idle_no_shift", bus.s_shift, 0);

    // Frame 0: one idle-output clock, 8 shift clocks, then the latch.
    bus.enable = 1'b1;
    step();
    check("start_edge_shift", bus.s_shift, 0);
    check("start_edge_busy", bus.busy, 0);
    for (int k = 0; k < CHANNELS; k++) begin
      step();
      check($sformatf("f0_shift_k%0d", k), {bus.s_shift, bus.s_data, bus.s_latch}, 3'b100);
    end
    step();
    check("f0_latch", {bus.s_latch, bus.s_shift, bus.busy}, 3'b101);
    check("f0_period_start", bus.period_start, 1);
    step();
    check("f1_starts_9_later", bus.s_shift, 1);

    // Period A: all duties 0; writes land in pending only.
    for (int c = 0; c < CHANNELS; c++) exp_duty[c] = 0;
    wr_addr_at[5]  = 0; wr_val_at[5]  = 10;
    wr_addr_at[6]  = 3; wr_val_at[6]  = 80;
    wr_addr_at[7]  = 6; wr_val_at[7]  = 255;
    wr_addr_at[8]  = 5; wr_val_at[8]  = 0;
    wr_addr_at[9]  = 7; wr_val_at[9]  = 200;
    wr_addr_at[10] = 7; wr_val_at[10] = 0;
    run_period("A", 1);

    // Period B: mid-period write to ch1, wrap-latch write to ch2.
    clear_writes();
    exp_duty = '{10, 0, 0, 80, 0, 0, 255, 0};
    wr_addr_at[50] = 1; wr_val_at[50] = 40;
    wr_addr_at[99] = 2; wr_val_at[99] = 30;
    run_period("B", 0);

    clear_writes();
    exp_duty = '{10, 40, 30, 80, 0, 0, 255, 0};
    run_period("C", 0);

    // Drop enable in the middle of the pwm_count=0 frame.
    n = 0;
    while (bus.s_shift !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check("drop_frame_start", bus.s_shift, 1);
    bits = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      bits[CHANNELS-1-k] = bus.s_data;
      if (k == 3) bus.enable = 1'b0;
      step();
    end
    check("drop_bits", bits, 8'b0100_1111);
    check("drop_latch", {bus.s_latch, bus.period_start, bus.busy}, 3'b111);
    step();
    check("drop_idle", {bus.s_shift, bus.s_latch, bus.busy, bus.s_data}, 4'b0000);
    seen = 1'b0;
    repeat (20) begin
      step();
      if (bus.s_shift || bus.s_latch || bus.busy) seen = 1'b1;
    end
    check("drop_quiet", seen, 0);

    // Resume at the held count 1: not a period start, same duties.
    bus.enable = 1'b1;
    capture_frame(1'b0, 0, 0, bits, ps);
    check("resume_bits", bits, 8'b0100_1111);
    check("resume_pstart", ps, 0);

    // Async reset in the middle of a shift.
    n = 0;
    while (bus.s_shift !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    step();
    step();
    #2;
    reset      = 1'b1;
    bus.enable = 1'b0;
    #1;
    check("arst_outputs", {bus.s_data, bus.s_shift, bus.s_latch, bus.period_start, bus.busy}, 5'b00000);
    seen = 1'b0;
    @(negedge clk);
    repeat (5) begin
      step();
      if (bus.s_latch || bus.s_shift) seen = 1'b1;
    end
    reset = 1'b0;
    repeat (5) begin
      step();
      if (bus.s_latch || bus.s_shift) seen = 1'b1;
    end
    check("arst_no_latch", seen, 0);

    // Duties and count were cleared: a fresh period of all-zero bits.
    bus.enable = 1'b1;
    capture_frame(1'b0, 0, 0, bits, ps);
    check("post_rst_bits", bits, 8'h00);
    check("post_rst_pstart", ps, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
